// File: rtl/mult_pkg.sv
// mult_pkg: shared types and sizing helpers for the radix-4 Booth multiplier
package mult_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} digit_t;
    function automatic int iter_count(input int width);
        return width / 2 + 1;
    endfunction
endpackage

// File: rtl/booth_r4_enc.sv
// booth_r4_enc: radix-4 Booth digit encoder and partial-product selector
module booth_r4_enc
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH+1:0] a,
    output digit_t           digit,
    output logic [WIDTH+2:0] pp
);
    logic [WIDTH+2:0] a1, a2;
    assign a1 = {a[WIDTH+1], a};
    assign a2 = {a, 1'b0};
    always_comb begin
        digit = (triplet == 3'b001 || triplet == 3'b010) ? P1 :
                (triplet == 3'b011) ? P2 :
                (triplet == 3'b100) ? M2 :
                (triplet == 3'b101 || triplet == 3'b110) ? M1 : ZERO;
        pp = (digit == P1) ? a1 :
             (digit == P2) ? a2 :
             (digit == M1) ? -a1 :
             (digit == M2) ? -a2 : '0;
    end
endmodule

// File: rtl/seq_booth_mult.sv
// seq_booth_mult: sequential radix-4 Booth multiplier, signed/unsigned per op,
// valid/ready on both sides; retires two multiplier bits per enabled cycle.
module seq_booth_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   inputA,
    input  logic [WIDTH-1:0]   inputB,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);
    localparam int ITER = iter_count(WIDTH);
    localparam int CW = $clog2(ITER + 1);
    localparam int EW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 4;

    state_t          state, state_n;
    digit_t          digit;
    logic [EW-1:0]   a_reg, b_sr;
    logic            b_prev;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc, acc_n, pp_ext;
    logic [EW:0]     pp;
    logic            accept, last;

    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign out_valid = state == DONE;
    assign accept    = en && in_valid && in_ready;
    assign last      = cnt == CW'(ITER - 1);

    booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
        .triplet ({b_sr[1:0], b_prev}),
        .a       (a_reg),
        .digit   (digit),
        .pp      (pp)
    );

    // partial product is weighted by 4^cnt rather than shifting the accumulator
    always_comb begin
        pp_ext  = {{(AW - EW - 1){pp[EW]}}, pp} << {cnt, 1'b0};
        acc_n   = (digit == ZERO) ? acc : acc + pp_ext;
        state_n = accept ? CALC :
                  (en && state == CALC && last) ? DONE :
                  (en && state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg  <= '0;
            b_sr   <= '0;
            b_prev <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
        end else if (accept) begin
            a_reg  <= signed_mode ? {{2{inputA[WIDTH-1]}}, inputA} : {2'b00, inputA};
            b_sr   <= signed_mode ? {{2{inputB[WIDTH-1]}}, inputB} : {2'b00, inputB};
            b_prev <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
        end else if (en && state == CALC) begin
            acc    <= acc_n;
            b_sr   <= {2'b00, b_sr[EW-1:2]};
            b_prev <= b_sr[1];
            cnt    <= cnt + 1'b1;
            if (last) result <= acc_n[2*WIDTH-1:0];
        end
    end
endmodule

// File: doc/seq_booth_mult.md
# seq_booth_mult

Parametrised radix-4 Booth sequential multiplier, the next generation of the team's 32-bit iterative shift-add multiplier. It retires two multiplier bits per cycle, supports signed and unsigned operands selected per operation, and uses valid/ready handshakes on both input and output. It sits between operand registers and any result consumer in the datapath.

## Interface
- WIDTH, 32, operand width; even, ≥4
- ITER, WIDTH/2+1 (derived localparam, not overridable), Booth iterations per operation
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  clock enable; low freezes all state, and handshakes do not complete
- in_valid  in  1  operands/mode present
- in_ready  out  1  block can accept operands
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
- inputA  in  WIDTH  multiplicand
- inputB  in  WIDTH  multiplier
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- result  out  2*WIDTH  product, signed or unsigned per captured mode

## Operation
- FSM states: IDLE, CALC, DONE. Reset → IDLE, in_ready=1, out_valid=0, result=0, counter=0.
- Accept: rising edge with en & in_valid & in_ready. Captures inputA and inputB, each extended to WIDTH+2 bits (sign-extended if signed_mode, else zero-extended). Clears the accumulator, counter=0, → CALC.
- CALC: each en cycle:
  - Encode the multiplier triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Add one of 0, ±A, ±2A to the accumulator.
  - Shift the multiplier right by 2 and increment the counter.
- After the ITER-th iteration: result ← low 2*WIDTH bits of the accumulator, → DONE.
- Arithmetic: accumulator is 2*WIDTH+4 bits, sign-correct. Results are exact for all operands, including signed −2^(WIDTH−1)·−2^(WIDTH−1) and unsigned (2^WIDTH−1)².
- DONE: out_valid=1, result stable.
  - out_ready without in_valid → IDLE.
  - out_ready with in_valid → accept the new operands directly (→ CALC).
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational from state and out_ready only.
- en low: state, counter, accumulator and outputs hold; in_ready and out_valid keep their values, but no transfer occurs.
- Reset mid-operation: immediate abort to reset values. The partial product is discarded and no out_valid is produced.
- In CALC, input pins are ignored; in_ready=0.

## Timing
- Latency: accept edge N → out_valid high after edge N+ITER (17 cycles at WIDTH=32, 5 at WIDTH=8), counting en-high cycles only.
- Throughput: one product per ITER+1 cycles when the consumer is always ready; back-to-back acceptance in DONE saves the IDLE cycle.
- result changes only on the edge entering DONE; it is held through DONE and IDLE until the next completion.
- out_valid deasserts on the edge after out_valid & out_ready.

## Structure
- Package mult_pkg holds:
  - state enum {IDLE, CALC, DONE}
  - Booth digit enum {ZERO, P1, P2, M1, M2}
  - function iter_count(WIDTH)
- Sub-module booth_r4_enc: combinational triplet → digit, plus a helper that produces the selected partial product (0/±A/±2A) at WIDTH+3 bits.
- Top holds the FSM, counter ($clog2(ITER+1) bits), multiplier shift register and accumulator.

## Test plan
- WIDTH=32, signed: (2,5)→10, (4,−3)→−12, (−7,6)→−42, (−7,−2)→14, (3,0)→0. Each out_valid exactly 17 cycles after acceptance.
- WIDTH=32, unsigned: (0xFFFFFFFF,0xFFFFFFFF)→0xFFFFFFFE00000001. Same inputs signed → 1.
- Extremes, WIDTH=8, signed: (−128,−128)→16384; (−128,127)→−16256; latency 5.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result and out_valid stable, in_ready=0. Then assert out_ready with in_valid=1 and (3,7) → accepted on the same edge, next result 21.
- en toggling 50% during CALC → correct product, latency = ITER en-high cycles. reset asserted mid-CALC → outputs zero immediately, in_ready=1 and no stale out_valid afterward.
- Random 10k ops per mode at WIDTH=8, 16 and 32 against a reference model, with random in_valid/out_ready → zero mismatches and no lost or duplicated results.
